// File: rtl/ptlrx_bank.sv
// ptlrx_bank: bank of NCH pulse-toggle receivers with a critical-timing
// window, fixed a-to-q latency and sticky per-channel violation flags.
// Optional feature: define PTLRX_VIOLCNT_EN to build the shared saturating
// violation counter; otherwise viol_cnt is tied to 0.

// One receiver channel: synchronizer, edge detect, window counter, toggle pipe.
module ptlrx_lane #(
    parameter int DELAY = 5,
    parameter int CT    = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic busy,
    output logic q,
    output logic viol
);
    // DELAY-1 pipe stages plus the q flop itself give DELAY edges of latency.
    localparam int         PW     = (DELAY > 1) ? DELAY - 1 : 1;
    localparam logic [7:0] WIN_LD = 8'(CT - 1);

    logic          a_s_q, a_s_d, a_d_q, a_d_d, q_q, q_d;
    logic [7:0]    win_q, win_d;
    logic [PW-1:0] pipe_q, pipe_d;
    logic          pulse, acc, tog;

    // Edge detect, accept/violate decision, window and pipe next-state.
    always_comb begin
        a_s_d  = a;
        a_d_d  = a_s_q;
        pulse  = (a_s_q != a_d_q) && !busy;
        acc    = pulse && (win_q == 8'd0);
        viol   = pulse && (win_q != 8'd0);
        win_d  = acc ? WIN_LD : ((win_q != 8'd0) ? win_q - 8'd1 : 8'd0);
        // With DELAY==1 the accepted pulse toggles q directly.
        pipe_d = (DELAY > 1) ? ((pipe_q << 1) | PW'(acc)) : '0;
        tog    = (DELAY > 1) ? pipe_q[PW-1] : acc;
        q_d    = q_q ^ tog;
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s_q  <= 1'b0;
            a_d_q  <= 1'b0;
            win_q  <= 8'd0;
            pipe_q <= '0;
            q_q    <= 1'b0;
        end else begin
            a_s_q  <= a_s_d;
            a_d_q  <= a_d_d;
            win_q  <= win_d;
            pipe_q <= pipe_d;
            q_q    <= q_d;
        end
    end

    assign q = q_q;
endmodule

module ptlrx_bank #(
    parameter int NCH     = 4,
    parameter int DELAY   = 5,
    parameter int CT      = 11,
    parameter int STARTUP = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] a,
    input  logic           err_clr,
    output logic [NCH-1:0] q,
    output logic [NCH-1:0] err,
    output logic [7:0]     viol_cnt
);
    logic [7:0]     st_cnt_q, st_cnt_d;
    logic           busy;
    logic [NCH-1:0] viol;
    logic [NCH-1:0] err_q, err_d;

    // Startup blanking counter and sticky error next-state; a new violation
    // wins over a coincident clear.
    always_comb begin
        busy     = (st_cnt_q != 8'd0);
        st_cnt_d = busy ? st_cnt_q - 8'd1 : 8'd0;
        err_d    = (err_q & ~{NCH{err_clr}}) | viol;
    end

    // Startup counter reloads on reset; error flags clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_cnt_q <= 8'(STARTUP);
            err_q    <= '0;
        end else begin
            st_cnt_q <= st_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        ptlrx_lane #(.DELAY(DELAY), .CT(CT)) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .a    (a[i]),
            .busy (busy),
            .q    (q[i]),
            .viol (viol[i])
        );
    end

`ifdef PTLRX_VIOLCNT_EN
    logic [7:0] cnt_q, cnt_d;
    logic [9:0] sum;

    // Add this cycle's violations (onto 0 when clearing) and saturate at 255.
    always_comb begin
        sum = err_clr ? 10'd0 : {2'b00, cnt_q};
        for (int i = 0; i < NCH; i++) sum = sum + 10'(viol[i]);
        cnt_d = (sum > 10'd255) ? 8'hff : sum[7:0];
    end

    // Violation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end

    assign viol_cnt = cnt_q;
`else
    assign viol_cnt = 8'd0;
`endif
endmodule
